// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM state type,
// default geometry and a helper that sizes the digit counter.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_AW  = 16;
    localparam int DEF_BW  = 16;
    localparam int DEF_DPC = 4;

    // One spare bit so the counter can represent the digit count itself.
    function automatic int cnt_width(input int ndigits);
        return $clog2(ndigits) + 1;
    endfunction

endpackage

// File: rtl/mul_iter_umul_axn.sv
// Combinational AW x DPC unsigned partial-product generator: sums
// AND-gated, shifted copies of the multiplicand, one per digit bit.
module umul_axn #(
    parameter int AW  = 16,
    parameter int DPC = 4
) (
    input  logic [AW-1:0]     a,
    input  logic [DPC-1:0]    d,
    output logic [AW+DPC-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < DPC; i++) begin
            p = p + ((AW+DPC)'(a & {AW{d[i]}}) << i);
        end
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative sign-magnitude multiplier: consumes DPC bits of |b| per cycle,
// fixed latency of BW/DPC cycles, valid/ready handshakes on both sides.
module mul_iter
    import mul_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int BW  = DEF_BW,
    parameter int DPC = DEF_DPC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW+BW-1:0] product
);

    localparam int ND = BW / DPC;
    localparam int CW = cnt_width(ND);
    localparam int PW = AW + BW;

    generate
        if (DPC < 1 || DPC > BW || (BW % DPC) != 0 || AW < 2) begin : g_bad_params
            $error("mul_iter: illegal parameter combination AW/BW/DPC");
        end
    endgenerate

    state_t            state;
    logic [AW-1:0]     a_mag;
    logic [BW-1:0]     b_rem;
    logic              neg;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     cnt;

    logic [AW-1:0]     a_abs;
    logic [BW-1:0]     b_abs;
    logic              neg_in;
    logic [AW+DPC-1:0] pp;
    logic [PW-1:0]     acc_next;

    // Unary minus at operand width keeps the most negative value lossless
    // once it is reinterpreted as an unsigned magnitude.
    always_comb begin
        a_abs  = (is_signed && a[AW-1]) ? -a : a;
        b_abs  = (is_signed && b[BW-1]) ? -b : b;
        neg_in = is_signed & (a[AW-1] ^ b[BW-1]);
    end

    umul_axn #(
        .AW  (AW),
        .DPC (DPC)
    ) u_axn (
        .a (a_mag),
        .d (b_rem[DPC-1:0]),
        .p (pp)
    );

    always_comb begin
        acc_next = acc + (PW'(pp) << (DPC * int'(cnt)));
    end

    // b_rem is shifted down each cycle so the current digit is always
    // its low DPC bits; the counter supplies the matching weight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_mag     <= '0;
            b_rem     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_mag    <= a_abs;
                        b_rem    <= b_abs;
                        neg      <= neg_in;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    cnt   <= cnt + CW'(1);
                    b_rem <= b_rem >> DPC;
                    if (cnt == CW'(ND - 1)) begin
                        product   <= neg ? -acc_next : acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        product   <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: three instances (DPC=4, 16, 1) checked every cycle
// against an arithmetic model, plus directed literal and latency checks.
module tb_mul_iter;

    logic        clk;
    logic        rst;
    logic        iv   [3];
    logic        ir   [3];
    logic [15:0] av   [3];
    logic [15:0] bv   [3];
    logic        sg   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [31:0] pr   [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          known;
        bit          in_ready;
        bit          out_valid;
        bit          rst_seen;
        logic [31:0] prod;
        logic [31:0] pend;
        int          left;
    } model_t;

    model_t m [3];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] exp;
    } vec_t;

    mul_iter #(.AW(16), .BW(16), .DPC(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
        .is_signed(sg[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .product(pr[0]));

    mul_iter #(.AW(16), .BW(16), .DPC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
        .is_signed(sg[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .product(pr[1]));

    mul_iter #(.AW(16), .BW(16), .DPC(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
        .is_signed(sg[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .product(pr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 16 : 1);
    endfunction

    // Reference product straight from integer arithmetic, truncated to 32 bits.
    function automatic logic [31:0] refMul(input logic [15:0] x, input logic [15:0] y, input logic s);
        longint sx, sy, p;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        p  = sx * sy;
        return p[31:0];
    endfunction

    function automatic model_t stepModel(input model_t s, input logic r, input logic v,
                                         input logic [15:0] x, input logic [15:0] y,
                                         input logic sgn, input logic ordyv, input int lat);
        model_t n;
        n = s;
        if (r) begin
            n.known     = 1'b1;
            n.in_ready  = 1'b1;
            n.out_valid = 1'b0;
            n.rst_seen  = 1'b1;
            n.prod      = '0;
            n.left      = 0;
        end else if (s.known) begin
            n.rst_seen = 1'b0;
            if (s.in_ready) begin
                if (v) begin
                    n.pend     = refMul(x, y, sgn);
                    n.left     = lat;
                    n.in_ready = 1'b0;
                end
            end else if (s.left > 0) begin
                n.left = s.left - 1;
                if (n.left == 0) begin
                    n.out_valid = 1'b1;
                    n.prod      = s.pend;
                end
            end else if (s.out_valid && ordyv) begin
                n.out_valid = 1'b0;
                n.in_ready  = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m[k] = '{known: 1'b0, in_ready: 1'b0, out_valid: 1'b0, rst_seen: 1'b0,
                     prod: '0, pend: '0, left: 0};
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            m[k] = stepModel(m[k], rst, iv[k], av[k], bv[k], sg[k], ordy[k], latOf(k));
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (m[k].known) begin
                checkOutput($sformatf("dut%0d in_ready", k), {31'd0, ir[k]}, {31'd0, m[k].in_ready});
                checkOutput($sformatf("dut%0d out_valid", k), {31'd0, ov[k]}, {31'd0, m[k].out_valid});
                if (m[k].out_valid || m[k].rst_seen) begin
                    checkOutput($sformatf("dut%0d product", k), pr[k], m[k].prod);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where out_valid is first seen.
    task automatic applyStimulus(input int k, input logic [15:0] x, input logic [15:0] y,
                                 input logic s, output logic [31:0] prod, output int lat);
        int n;
        n = 0;
        while (!ir[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) checkOutput($sformatf("dut%0d in_ready timeout", k), 32'd0, 32'd1);
        av[k] = x;
        bv[k] = y;
        sg[k] = s;
        iv[k] = 1'b1;
        @(negedge clk);
        av[k] = ~x;
        bv[k] = y ^ 16'h5A5A;
        sg[k] = ~s;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) iv[k] = 1'b0;
        end while (!ov[k] && lat < 100);
        if (!ov[k]) checkOutput($sformatf("dut%0d out_valid timeout", k), 32'd0, 32'd1);
        prod = pr[k];
    endtask

    task automatic runRandom(input int k);
        logic [15:0] specials [5];
        logic [15:0] x, y;
        logic        s;
        logic [31:0] p;
        int          lat;
        specials = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h7FFF};
        for (int i = 0; i < 1000; i++) begin
            x = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
            y = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
            s = 1'($urandom);
            applyStimulus(k, x, y, s, p, lat);
            checkOutput($sformatf("dut%0d rand %h*%h s=%0d", k, x, y, s), p, refMul(x, y, s));
            checkOutput($sformatf("dut%0d rand latency", k), 32'(lat), 32'(latOf(k)));
        end
    endtask

    initial begin
        vec_t        vecs [5];
        logic [31:0] p;
        int          lat;
        bit          seen;

        vecs = '{
            '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001},
            '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001},
            '{16'h8000, 16'h8000, 1'b1, 32'h40000000},
            '{16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA},
            '{16'd1234, 16'h0000, 1'b0, 32'h00000000}
        };

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; av[k] = '0; bv[k] = '0; sg[k] = 1'b0; ordy[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset in_ready", {31'd0, ir[0]}, 32'd1);
        checkOutput("reset out_valid", {31'd0, ov[0]}, 32'd0);
        checkOutput("reset product", pr[0], 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
            checkOutput($sformatf("vec%0d product", i), p, vecs[i].exp);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
        end

        $display("[TB] back-pressure hold");
        @(negedge clk);
        ordy[0] = 1'b0;
        applyStimulus(0, 16'd100, 16'd200, 1'b0, p, lat);
        checkOutput("bp product", p, 32'd20000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp out_valid held", {31'd0, ov[0]}, 32'd1);
            checkOutput("bp product held", pr[0], 32'd20000);
            checkOutput("bp in_ready low", {31'd0, ir[0]}, 32'd0);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        checkOutput("bp release out_valid", {31'd0, ov[0]}, 32'd0);
        checkOutput("bp release in_ready", {31'd0, ir[0]}, 32'd1);

        $display("[TB] reset during CALC");
        av[0] = 16'h1234; bv[0] = 16'h5678; sg[0] = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid reset in_ready", {31'd0, ir[0]}, 32'd1);
        checkOutput("mid reset product", pr[0], 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        checkOutput("no out_valid after reset", {31'd0, seen}, 32'd0);
        applyStimulus(0, 16'd7, 16'd9, 1'b0, p, lat);
        checkOutput("7x9 product", p, 32'd63);
        checkOutput("7x9 latency", 32'(lat), 32'd4);

        $display("[TB] accept coinciding with reset");
        @(negedge clk);
        av[0] = 16'd5; bv[0] = 16'd5; iv[0] = 1'b1; rst = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0; rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov[0] || !ir[0]) seen = 1'b1;
        end
        checkOutput("reset-accept ignored", {31'd0, seen}, 32'd0);

        $display("[TB] random runs on DPC=1 and DPC=16");
        fork
            runRandom(1);
            runRandom(2);
        join

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
